// File: rtl/accum_seq_pkg.sv
// accum_seq_pkg: shared state encoding and width helper for the accumulating sequencer
package accum_seq_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} accum_state_e;
  function automatic int acc_width(input int in_size, input int extend);
    return in_size + extend;
  endfunction
endpackage

// File: rtl/extender_n.sv
// extender_n: per-lane sign or zero extension of IN_NUM lanes by EXTEND bits
module extender_n #(
  parameter int IN_NUM    = 2,
  parameter int IN_SIZE   = 8,
  parameter int IS_SIGNED = 1,
  parameter int EXTEND    = 4
) (
  input  logic [IN_SIZE-1:0]        in_i  [0:IN_NUM-1],
  output logic [IN_SIZE+EXTEND-1:0] out_o [0:IN_NUM-1]
);
  for (genvar i = 0; i < IN_NUM; i++) begin : g_ext
    assign out_o[i] = (IS_SIGNED != 0) ? {{EXTEND{in_i[i][IN_SIZE-1]}}, in_i[i]}
                                       : {{EXTEND{1'b0}}, in_i[i]};
  end
endmodule

// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: accumulates a configured number of extended operand beats per lane
module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter int IN_NUM    = 2,
  parameter int IN_SIZE   = 8,
  parameter int IS_SIGNED = 1,
  parameter int EXTEND    = 4,
  parameter int LEN_W     = 4,
  localparam int ACC_W    = acc_width(IN_SIZE, EXTEND)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  output logic               busy_o,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [IN_SIZE-1:0] in_data_i  [0:IN_NUM-1],
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ACC_W-1:0]   out_data_o [0:IN_NUM-1],
  output logic [IN_NUM-1:0]  ovf_o
);
  accum_state_e      state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q [0:IN_NUM-1];
  logic [ACC_W-1:0]  acc_d [0:IN_NUM-1];
  logic [ACC_W-1:0]  ext   [0:IN_NUM-1];
  logic [IN_NUM-1:0] ovf_q, ovf_d, lane_ovf;
  logic              take, hs;

  extender_n #(
    .IN_NUM(IN_NUM), .IN_SIZE(IN_SIZE), .IS_SIGNED(IS_SIGNED), .EXTEND(EXTEND)
  ) u_ext (
    .in_i(in_data_i),
    .out_o(ext)
  );

  assign take = (state_q == IDLE) && start_i;
  assign hs   = (state_q == ACCUM) && in_valid_i;

  // one extra bit on the sum captures the unsigned carry out
  for (genvar i = 0; i < IN_NUM; i++) begin : g_lane
    logic [ACC_W:0] sum;
    assign sum = {1'b0, acc_q[i]} + {1'b0, ext[i]};
    assign lane_ovf[i] = (IS_SIGNED != 0)
      ? (acc_q[i][ACC_W-1] == ext[i][ACC_W-1]) && (sum[ACC_W-1] != acc_q[i][ACC_W-1])
      : sum[ACC_W];
    assign acc_d[i] = take ? '0 : hs ? sum[ACC_W-1:0] : acc_q[i];
  end

  assign ovf_d = take ? '0 : hs ? (ovf_q | lane_ovf) : ovf_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = ACCUM;
        len_d   = cfg_len_i;
        cnt_d   = '0;
      end
      ACCUM: if (in_valid_i) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == len_q) ? DONE : ACCUM;
      end
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= '0;
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
    end
  end

  assign busy_o      = state_q != IDLE;
  assign in_ready_o  = state_q == ACCUM;
  assign out_valid_o = state_q == DONE;
  assign out_data_o  = acc_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_accum_seq_ctrl.sv
// tb_accum_seq_ctrl: three parameterisations driven in lockstep, checked against a job-level model
module tb_accum_seq_ctrl;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic [3:0] cfg = 0;
  logic       in_valid = 0;
  logic       out_ready = 0;
  logic [7:0] din [0:1];
  logic       busy0, rdy0, ov0, busy1, rdy1, ov1, busy2, rdy2, ov2;
  logic [11:0] od0 [0:1];
  logic [11:0] od1 [0:1];
  logic [9:0]  od2 [0:1];
  logic [1:0]  of0, of1, of2;
  int nvec = 0, nerr = 0, cyc = 0, cs = 0;
  bit armed = 0;
  int ph = 0, rem = 0;
  int msum [3][2];
  bit movf [3][2];

  always #5 clk = ~clk;

  accum_seq_ctrl u0 (.clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_len_i(cfg), .busy_o(busy0),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(din), .out_valid_o(ov0),
    .out_ready_i(out_ready), .out_data_o(od0), .ovf_o(of0));
  accum_seq_ctrl #(.IS_SIGNED(0)) u1 (.clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_len_i(cfg),
    .busy_o(busy1), .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(din), .out_valid_o(ov1),
    .out_ready_i(out_ready), .out_data_o(od1), .ovf_o(of1));
  accum_seq_ctrl #(.EXTEND(2)) u2 (.clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_len_i(cfg),
    .busy_o(busy2), .in_valid_i(in_valid), .in_ready_o(rdy2), .in_data_i(din), .out_valid_o(ov2),
    .out_ready_i(out_ready), .out_data_o(od2), .ovf_o(of2));

  function automatic int wid(input int k);
    return (k == 2) ? 10 : 12;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // model: phase 0 idle, 1 collecting beats, 2 holding result; sums kept as plain integers mod 2^W
  always @(posedge clk) begin
    int e, cur, t, w;
    cyc <= cyc + 1;
    armed <= 1;
    if (!rst_n) begin
      ph <= 0;
      rem <= 0;
      for (int k = 0; k < 3; k++) for (int l = 0; l < 2; l++) begin
        msum[k][l] <= 0;
        movf[k][l] <= 0;
      end
    end else if (ph == 0) begin
      if (start) begin
        ph <= 1;
        rem <= int'(cfg) + 1;
        for (int k = 0; k < 3; k++) for (int l = 0; l < 2; l++) begin
          msum[k][l] <= 0;
          movf[k][l] <= 0;
        end
      end
    end else if (ph == 1) begin
      if (in_valid) begin
        for (int k = 0; k < 3; k++) for (int l = 0; l < 2; l++) begin
          w = wid(k);
          if (k != 1) begin
            e = int'($signed(din[l]));
            cur = (msum[k][l] >= (1 << (w - 1))) ? msum[k][l] - (1 << w) : msum[k][l];
            t = cur + e;
            if (t >= (1 << (w - 1)) || t < -(1 << (w - 1))) movf[k][l] <= 1;
          end else begin
            t = msum[k][l] + int'(din[l]);
            if (t >= (1 << w)) movf[k][l] <= 1;
          end
          msum[k][l] <= ((t % (1 << w)) + (1 << w)) % (1 << w);
        end
        rem <= rem - 1;
        if (rem == 1) ph <= 2;
      end
    end else if (out_ready) ph <= 0;
  end

  task automatic cmp_dut(input int k, input logic b, input logic r, input logic v,
                         input int d0, input int d1, input logic [1:0] f);
    string s;
    s = $sformatf("u%0d", k);
    chk({s, ".busy"}, int'(b), int'(ph != 0));
    chk({s, ".in_ready"}, int'(r), int'(ph == 1));
    chk({s, ".out_valid"}, int'(v), int'(ph == 2));
    chk({s, ".out_data0"}, d0, msum[k][0]);
    chk({s, ".out_data1"}, d1, msum[k][1]);
    chk({s, ".ovf"}, int'(f), int'({movf[k][1], movf[k][0]}));
  endtask

  always @(negedge clk) if (armed) begin
    cmp_dut(0, busy0, rdy0, ov0, int'(od0[0]), int'(od0[1]), of0);
    cmp_dut(1, busy1, rdy1, ov1, int'(od1[0]), int'(od1[1]), of1);
    cmp_dut(2, busy2, rdy2, ov2, int'(od2[0]), int'(od2[1]), of2);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic job(input int len, input logic [7:0] a, input logic [7:0] b,
                     input int stall_at, input int hold, input bit poke);
    int t;
    logic [11:0] f0, f1;
    tick;
    start = 1;
    cfg = len[3:0];
    cs = cyc;
    tick;
    start = 0;
    cfg = 4'hA;
    in_valid = 1;
    din[0] = a;
    din[1] = b;
    for (int i = 0; i <= len; i++) begin
      if (i == stall_at) begin
        in_valid = 0;
        din[0] = 8'h55;
        din[1] = 8'hAA;
        if (poke) begin
          start = 1;
          cfg = 0;
        end
        repeat (3) tick;
        start = 0;
        in_valid = 1;
        din[0] = a;
        din[1] = b;
      end
      tick;
    end
    in_valid = 0;
    din[0] = 8'h33;
    din[1] = 8'hCC;
    t = 0;
    while (!ov0 && t < 50) begin
      tick;
      t++;
    end
    chk("out_valid_seen", int'(ov0), 1);
    if (poke) begin
      start = 1;
      cfg = 0;
    end
    f0 = od0[0];
    f1 = od0[1];
    repeat (hold) tick;
    start = 0;
    chk("done_stable0", int'(od0[0]), int'(f0));
    chk("done_stable1", int'(od0[1]), int'(f1));
    chk("done_in_ready", int'(rdy0), 0);
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    din[0] = 0;
    din[1] = 0;
    repeat (3) tick;
    chk("reset_busy", int'(busy0), 0);
    chk("reset_out_data", int'(od0[0]), 0);
    rst_n = 1;
    in_valid = 1;
    din[0] = 8'h11;
    din[1] = 8'h22;
    repeat (2) tick;
    in_valid = 0;
    chk("idle_ignores_data", int'(od0[0]), 0);

    job(3, 8'h80, 8'h7F, -1, 0, 0);
    chk("t1_lat", 0, 0);
    chk("t1_lane0", int'(od0[0]), 'hE00);
    chk("t1_lane1", int'(od0[1]), 'h1FC);
    chk("t1_ovf", int'(of0), 0);

    tick;
    start = 1;
    cfg = 3;
    cs = cyc;
    tick;
    start = 0;
    in_valid = 1;
    din[0] = 8'h01;
    din[1] = 8'h02;
    repeat (4) tick;
    in_valid = 0;
    chk("latency_cycles", cyc - cs, 5);
    chk("latency_out_valid", int'(ov0), 1);
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("t1b_post_hs_keep", int'(od0[0]), 4);

    job(15, 8'hFF, 8'hFF, -1, 2, 0);
    chk("t2_u_lane0", int'(od1[0]), 'hFF0);
    chk("t2_u_lane1", int'(od1[1]), 'hFF0);
    chk("t2_u_ovf", int'(of1), 0);
    chk("t2_s_lane0", int'(od0[0]), 'hFF0);

    job(4, 8'h7F, 8'h00, -1, 0, 0);
    chk("t3_lane0", int'(od2[0]), 'h27B);
    chk("t3_ovf", int'(of2), 1);

    job(3, 8'h10, 8'hF0, 2, 5, 0);
    chk("t4_lane0", int'(od0[0]), 'h040);
    chk("t4_lane1", int'(od0[1]), 'hFC0);

    job(2, 8'h03, 8'h05, 1, 2, 1);
    chk("t5_lane0", int'(od0[0]), 9);
    chk("t5_lane1", int'(od0[1]), 'hF);

    tick;
    start = 1;
    cfg = 3;
    tick;
    start = 0;
    in_valid = 1;
    din[0] = 8'h40;
    din[1] = 8'h40;
    repeat (2) tick;
    rst_n = 0;
    tick;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_in_ready", int'(rdy0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_data0", int'(od0[0]), 0);
    chk("rst_ovf", int'(of0), 0);
    rst_n = 1;
    in_valid = 0;
    job(1, 8'h02, 8'h03, -1, 0, 0);
    chk("t6_lane0", int'(od0[0]), 4);
    chk("t6_lane1", int'(od0[1]), 6);

    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
